// File: rtl/fp_exp_bias_adjust_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_exp_bias_adjust_if
// Description : Upstream and downstream valid/ready bus of the exponent
//               bias-adjust stage.
// Revision    : 1.0  initial release
// ============================================================================
interface fp_exp_bias_adjust_if #(
    parameter int EXP_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [EXP_W-1:0] exp_sum;
    logic             exp_carry;
    logic             norm_inc;
    logic             in_zero;
    logic             out_valid;
    logic             out_ready;
    logic [EXP_W-1:0] exp_out;
    logic             ovf;
    logic             unf;
    logic             zero;

    modport master (
        output in_valid, exp_sum, exp_carry, norm_inc, in_zero, out_ready,
        input  in_ready, out_valid, exp_out, ovf, unf, zero
    );

    modport slave (
        input  in_valid, exp_sum, exp_carry, norm_inc, in_zero, out_ready,
        output in_ready, out_valid, exp_out, ovf, unf, zero
    );
endinterface
`default_nettype wire

// File: rtl/fp_exp_bias_adjust.sv
`default_nettype none
// ============================================================================
// Module      : fp_exp_bias_adjust
// Description : Two-stage pipeline that removes the exponent bias, applies the
//               normalisation increment and saturates to the IEEE exponent
//               range. Optional overflow/underflow counters: FP_EXP_STATS_EN.
// Revision    : 1.0  initial release
// ============================================================================
module fp_exp_bias_adjust #(
    parameter int EXP_W = 8,
    parameter int BIAS  = 127
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    fp_exp_bias_adjust_if.slave     bus
`ifdef FP_EXP_STATS_EN
    ,
    input  wire logic               clr_stats_i,
    output logic [15:0]             ovf_count_o,
    output logic [15:0]             unf_count_o
`endif
);
    localparam int                       RAW_W     = EXP_W + 2;
    localparam logic [RAW_W-1:0]         c_bias    = RAW_W'(BIAS);
    localparam logic signed [RAW_W-1:0]  c_ovf_lim = RAW_W'((1 << EXP_W) - 1);

    logic             s1_valid_q, s1_valid_d;
    logic [RAW_W-1:0] s1_raw_q,   s1_raw_d;
    logic             s1_zero_q,  s1_zero_d;
    logic             s2_valid_q, s2_valid_d;
    logic [EXP_W-1:0] exp_q,      exp_d;
    logic             ovf_q,      ovf_d;
    logic             unf_q,      unf_d;
    logic             zero_q,     zero_d;

    logic                    w_s2_free;
    logic                    w_in_fire;
    logic                    w_adv;
    logic [RAW_W-1:0]        w_raw_in;
    logic signed [RAW_W-1:0] w_r;
    logic                    w_ovf;
    logic                    w_unf;

    assign w_s2_free    = !s2_valid_q || bus.out_ready;
    assign bus.in_ready = !s1_valid_q || w_s2_free;
    assign w_in_fire    = bus.in_valid && bus.in_ready;
    assign w_adv        = s1_valid_q && w_s2_free;

    // Two spare bits: one for the increment carry, one for the sign after bias removal.
    assign w_raw_in = RAW_W'({bus.exp_carry, bus.exp_sum}) + RAW_W'(bus.norm_inc);
    assign w_r      = $signed(s1_raw_q - c_bias);
    assign w_ovf    = (w_r >= c_ovf_lim);
    assign w_unf    = w_r[RAW_W-1] || (w_r == '0);

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_raw_d   = s1_raw_q;
        s1_zero_d  = s1_zero_q;
        s2_valid_d = s2_valid_q;
        exp_d      = exp_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        zero_d     = zero_q;

        if (w_s2_free) begin
            s2_valid_d = s1_valid_q;
        end

        if (w_adv) begin
            s1_valid_d = 1'b0;
            ovf_d      = 1'b0;
            unf_d      = 1'b0;
            zero_d     = 1'b0;
            if (s1_zero_q) begin
                exp_d  = '0;
                zero_d = 1'b1;
            end else if (w_ovf) begin
                exp_d  = '1;
                ovf_d  = 1'b1;
            end else if (w_unf) begin
                exp_d  = '0;
                unf_d  = 1'b1;
            end else begin
                exp_d  = w_r[EXP_W-1:0];
            end
        end

        if (w_in_fire) begin
            s1_valid_d = 1'b1;
            s1_raw_d   = w_raw_in;
            s1_zero_d  = bus.in_zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_raw_q   <= '0;
            s1_zero_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            exp_q      <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_raw_q   <= s1_raw_d;
            s1_zero_q  <= s1_zero_d;
            s2_valid_q <= s2_valid_d;
            exp_q      <= exp_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            zero_q     <= zero_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.exp_out   = exp_q;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;
    assign bus.zero      = zero_q;

`ifdef FP_EXP_STATS_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;
    logic [15:0] unf_cnt_q, unf_cnt_d;
    logic        w_out_fire;

    assign w_out_fire = s2_valid_q && bus.out_ready;

    // Clear takes precedence over a same-edge increment.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        unf_cnt_d = unf_cnt_q;
        if (clr_stats_i) begin
            ovf_cnt_d = '0;
            unf_cnt_d = '0;
        end else if (w_out_fire) begin
            if (ovf_q && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_d = ovf_cnt_q + 16'd1;
            if (unf_q && (unf_cnt_q != 16'hFFFF)) unf_cnt_d = unf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= '0;
            unf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
            unf_cnt_q <= unf_cnt_d;
        end
    end

    assign ovf_count_o = ovf_cnt_q;
    assign unf_count_o = unf_cnt_q;
`endif
endmodule
`default_nettype wire
